// File: rtl/poc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poc_pkg
//  Purpose  : Shared types and constants for the multi-channel programmable
//             output controller (poc_mc / poc_chan).
//  Contents : poc_state_t  - per-channel handshake FSM states
//             MODE_POLL    - channel operates in polling mode
//             MODE_INT     - channel raises irq when drained
//  Revision : 1.0 - initial release
// ============================================================================
package poc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } poc_state_t;

  localparam logic MODE_POLL = 1'b0;
  localparam logic MODE_INT  = 1'b1;

endpackage : poc_pkg
`default_nettype wire

// File: rtl/poc_chan.sv
`default_nettype none
// ============================================================================
//  Module   : poc_chan
//  Purpose  : One output channel: FIFO, TR/RDY handshake FSM and the
//             mode / overflow / interrupt / ready status registers.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             push, wdata     - decoded CPU data write for this channel
//             mode_we,mode_val- decoded mode write (also clears ovf)
//             rdy             - peripheral ready input
//             tr, data        - transfer strobe and held data word
//             ready, irq, ovf - registered status outputs
//  Revision : 1.0 - initial release
// ============================================================================
module poc_chan
  import poc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mode_we,
  input  logic              mode_val,
  input  logic              rdy,
  output logic              tr,
  output logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              irq,
  output logic              ovf
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_cnt;
  poc_state_t        r_state;
  logic              r_mode;

  logic w_empty;
  logic w_pop;
  logic w_accept;

  assign w_empty  = (r_cnt == '0);
  assign w_pop    = (r_state == IDLE) && !w_empty && rdy;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign w_accept = push && ((r_cnt != FULL) || w_pop);

  // Storage carries no reset: occupancy is tracked solely by r_cnt.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wp] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_mode  <= MODE_POLL;
      tr      <= 1'b0;
      data    <= '0;
      ready   <= 1'b1;
      irq     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_accept) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            data    <= r_mem[r_rp];
            tr      <= 1'b1;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          tr      <= 1'b0;
          r_state <= WAIT_LO;
        end
        WAIT_LO: if (!rdy) r_state <= WAIT_HI;
        WAIT_HI: if (rdy)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (mode_we) r_mode <= mode_val;

      // A rejected push in the same cycle as a mode write leaves ovf set:
      // the overflow is the more recent event.
      if (push && !w_accept) begin
        ovf <= 1'b1;
      end else if (mode_we) begin
        ovf <= 1'b0;
      end

      ready <= (r_cnt != FULL);
      irq   <= (r_mode == MODE_INT) && w_empty && (r_state == IDLE);
    end
  end

endmodule : poc_chan
`default_nettype wire

// File: rtl/poc_mc.sv
`default_nettype none
// ============================================================================
//  Module   : poc_mc
//  Purpose  : Multi-channel programmable output controller. Decodes CPU
//             data/mode writes to a channel and instantiates one poc_chan
//             per channel; channels run fully independently.
//  Ports    : CLK, RSTn              - clock, asynchronous active-low reset
//             cpu_we, cpu_ch,
//             cpu_wdata              - data write strobe, channel, word
//             mode_we, mode_val      - mode write (0 poll, 1 interrupt)
//             pr_rdy / pr_tr /
//             pr_data                - per-channel peripheral handshake
//             ready, irq, ovf        - per-channel status
//  Revision : 1.0 - initial release
// ============================================================================
module poc_mc
  import poc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       cpu_we,
  input  logic [CH_W-1:0]            cpu_ch,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       mode_we,
  input  logic                       mode_val,
  input  logic [CHANNELS-1:0]        pr_rdy,
  output logic [CHANNELS-1:0]        pr_tr,
  output logic [CHANNELS*DATA_W-1:0] pr_data,
  output logic [CHANNELS-1:0]        ready,
  output logic [CHANNELS-1:0]        irq,
  output logic [CHANNELS-1:0]        ovf
);

  // Channel indices >= CHANNELS match no instance and are thereby ignored.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic w_sel;
    assign w_sel = (cpu_ch == CH_W'(i));

    poc_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk      (CLK),
      .rst_n    (RSTn),
      .push     (cpu_we && w_sel),
      .wdata    (cpu_wdata),
      .mode_we  (mode_we && w_sel),
      .mode_val (mode_val),
      .rdy      (pr_rdy[i]),
      .tr       (pr_tr[i]),
      .data     (pr_data[i*DATA_W +: DATA_W]),
      .ready    (ready[i]),
      .irq      (irq[i]),
      .ovf      (ovf[i])
    );
  end

endmodule : poc_mc
`default_nettype wire
